ahp_slave_mem: RTL
==================

# ahp_slave_mem

AHB-Lite memory responder: the slave end of the bus driven by the team's AHP master. It decodes address phases, inserts a configurable number of wait states, and commits writes or returns reads from an internal word-organised RAM with byte-lane enables. Out-of-range and misaligned accesses receive a two-cycle ERROR response. It sits on the master's bus as the default memory target; an external decoder provides HSEL.

## Interface
- DEPTH, 256: RAM size in 32-bit words; power of two, 16..4096.
- WAIT_STATES, 0: HREADYOUT-low cycles per OKAY data phase, 0..7.
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; 3..7 are illegal.
- HBURST  in  3  sampled but unused; each beat is decoded on its own HADDR.
- HTRANS  in  HTRANS_ENUM  IDLE/BUSY/NON_SEQ/SEQ.
- HWDATA  in  32 signed  write data, valid in the data phase.
- HREADY  in  1  bus-level ready, the muxed HREADYOUT of the active slave.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32 signed  read data, valid when HREADYOUT = 1 in a read data phase.

## Operation
- Address-phase accept on an edge with HSEL && HREADY && HTRANS ∈ {NON_SEQ, SEQ}. Capture HADDR, HWRITE, HSIZE and the error flag.
- IDLE, BUSY and unselected cycles produce no access and no state change. The slave drives HREADYOUT = 1, HRESP = 0.
- Word index is HADDR[log2(DEPTH)+1:2]. Byte lanes are little-endian:
  - byte: lane HADDR[1:0].
  - half: lanes {HADDR[1],0}+{0,1}.
  - word: all four lanes.
- Error conditions (error feature enabled):
  - HADDR ≥ 4·DEPTH;
  - HSIZE > 2;
  - half with HADDR[0] = 1;
  - word with HADDR[1:0] ≠ 0.
- FSM states:
  - ST_IDLE: no pending transfer; HREADYOUT = 1.
    - accept+error → ST_ERR1.
    - accept, WAIT_STATES > 0 → ST_WAIT, counter = WAIT_STATES.
    - accept, WAIT_STATES = 0 → ST_DATA.
  - ST_WAIT: HREADYOUT = 0; the counter decrements each edge. Counter = 1 → ST_DATA.
  - ST_DATA: HREADYOUT = 1, HRESP = 0.
    - Write: commits the enabled HWDATA lanes on this edge.
    - Read: HRDATA holds the word.
    - A new accept on the same edge is pipelined, with the same transitions as ST_IDLE. Otherwise → ST_IDLE.
  - ST_ERR1: HREADYOUT = 0, HRESP = 1 → ST_ERR2.
  - ST_ERR2: HREADYOUT = 1, HRESP = 1. A new accept is allowed, with the same transitions as ST_IDLE.
- Errored writes never modify the RAM. Errored reads leave HRDATA unchanged.
- HRDATA register load:
  - WAIT_STATES = 0: loads on the accept edge.
  - WAIT_STATES > 0: loads on the edge leaving the last ST_WAIT cycle.
  - It holds its value at all other times.
- Read-after-write bypass: a read accepted on the same edge as a committing write to the same word returns the merged new data, with the new lanes taking priority.

## Timing
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = ST_IDLE, counter = 0. RAM contents are not reset.
- Reset asserted mid-wait or mid-error: the pending transfer is discarded with no RAM write, and outputs take their reset values immediately.
- OKAY transfer latency:
  - 1 + WAIT_STATES data-phase cycles.
  - Back-to-back throughput at WAIT_STATES = 0 is one beat per cycle.
- ERROR is always exactly 2 data-phase cycles, regardless of WAIT_STATES.
- HREADY low from another slave's data phase blocks accept. The slave ignores HTRANS while HREADY = 0.

## Configuration
- AHP_SLAVE_ERROR_RESP_EN defined: error detection and the two-cycle ERROR response as above.
- Undefined:
  - HRESP is tied to 0.
  - Out-of-range addresses wrap modulo DEPTH.
  - Misaligned accesses are force-aligned: the low address bits are ignored for lane selection beyond HSIZE.
  - HSIZE > 2 is treated as a word access.
  - ST_ERR1 and ST_ERR2 do not exist.

## Structure
- Add to AHP_MASTER_PKG:
  - HRESP_OKAY / HRESP_ERROR constants;
  - SIZE_BYTE / SIZE_HALF / SIZE_WORD constants;
  - typedef enum SLAVE_STATE_ENUM {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2}.
- HTRANS_ENUM is reused unchanged.
- Sub-module ahp_slave_ram:
  - DEPTH×32 synchronous-write RAM, 4-bit byte enable;
  - combinational read port;
  - no reset.

## Test plan
- Reset, then a word write of 0x12345678 to 0x10 followed by a word read of 0x10, WAIT_STATES = 0 → HREADYOUT stays 1 and the read returns 0x12345678 in the next cycle (bypass path).
- Byte write 0xAB to 0x11, then word read of 0x10 → 0x1234AB78. Half write 0xCDEF to 0x12 → 0xCDEFAB78.
- WAIT_STATES = 3, read of 0x10 → HREADYOUT low for exactly 3 cycles, then high with data valid.
- Macro defined: word write to 4·DEPTH, then word read of 0x02 → each gives HREADYOUT 0/1 with HRESP 1/1, and RAM word 0 is unchanged.
- NON_SEQ, BUSY, SEQ sequence with HSEL low in the middle cycle → BUSY and unselected cycles are OKAY zero-wait with no RAM change. Both beats complete.
- HRESETn pulsed low during a ST_WAIT write → HREADYOUT = 1 asynchronously, and a later read shows the old data.

Source files
------------

// File: rtl/ahp_slave_mem_pkg.sv
// Shared types for the AHP bus: transfer encoding, response and size codes, slave FSM states.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
// AHP_SLAVE_ERROR_RESP_EN adds the two ERROR-response states to SLAVE_STATE_ENUM.
package ahp_slave_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    NON_SEQ = 2'b10,
    SEQ     = 2'b11
  } HTRANS_ENUM;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2
`ifdef AHP_SLAVE_ERROR_RESP_EN
    ,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
`endif
  } SLAVE_STATE_ENUM;

  // Little-endian byte-lane enables; low address bits beyond the access size are ignored,
  // and any size code above word behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << lo;
      SIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahp_slave_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous read port.
// Latency: write lands on the rising edge; read data follows rd_idx combinationally.
// Backpressure: none; accepts a write every cycle. Contents are not reset.
module ahp_slave_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_dat,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_dat
);

  logic [31:0] mem [DEPTH];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/ahp_slave_mem.sv
// AHB-Lite memory slave: decodes address phases, inserts WAIT_STATES wait cycles, reads/writes a byte-lane RAM.
// Latency: 1 + WAIT_STATES data-phase cycles per OKAY beat; ERROR responses take exactly 2 cycles.
// Backpressure: stalls the bus via HREADYOUT; ignores HTRANS while HREADY is low. AHP_SLAVE_ERROR_RESP_EN enables ERROR responses.
module ahp_slave_mem
  import ahp_slave_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  HTRANS_ENUM         HTRANS,
  input  logic signed [31:0] HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic signed [31:0] HRDATA
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  SLAVE_STATE_ENUM state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;

  // Captured address phase of the transfer currently in its data phase.
  logic [AW-1:0]   ap_idx;
  logic [3:0]      ap_be;
  logic            ap_write;

  logic            accept, can_accept, take;
  logic [AW-1:0]   addr_idx, rd_idx;
  logic [3:0]      addr_be;
  logic            addr_err;
  logic            wr_commit, rd_load;
  logic [31:0]     ram_rd, rd_merged;
  logic            unused_bits;

  assign accept     = HSEL && HREADY && ((HTRANS == NON_SEQ) || (HTRANS == SEQ));
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA)
`ifdef AHP_SLAVE_ERROR_RESP_EN
                      || (state == ST_ERR2)
`endif
                      ;
  assign take       = accept && can_accept;

  // Out-of-range addresses wrap when errors are not reported, since the index drops the high bits.
  assign addr_idx = HADDR[AW+1:2];
  assign addr_be  = lane_mask(HSIZE, HADDR[1:0]);

`ifdef AHP_SLAVE_ERROR_RESP_EN
  assign addr_err = (HADDR[31:AW+2] != '0) ||
                    (HSIZE > SIZE_WORD) ||
                    ((HSIZE == SIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign unused_bits = ^HBURST;
`else
  assign addr_err    = 1'b0;
  assign unused_bits = ^{HBURST, HADDR[31:AW+2]};
`endif

  // A write commits on the edge that ends its single ready data-phase cycle.
  assign wr_commit = (state == ST_DATA) && ap_write;

  // Zero-wait reads sample the RAM at the accept edge; waited reads use the captured index.
  assign rd_idx  = (WAIT_STATES == 0) ? addr_idx : ap_idx;
  assign rd_load = (WAIT_STATES == 0) ? (take && !HWRITE && !addr_err)
                                      : ((state == ST_WAIT) && (cnt == 3'd1) && !ap_write);

  ahp_slave_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .HCLK   (HCLK),
    .wr_en  (wr_commit),
    .wr_be  (ap_be),
    .wr_idx (ap_idx),
    .wr_dat (HWDATA),
    .rd_idx (rd_idx),
    .rd_dat (ram_rd)
  );

  // Forward lanes of a write committing on the same edge so a back-to-back read sees new data.
  always_comb begin
    rd_merged = ram_rd;
    for (int b = 0; b < 4; b++) begin
      if (wr_commit && (ap_idx == rd_idx) && ap_be[b]) rd_merged[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  // Next-state, wait counter and bus response for the current state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_nxt   = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = ST_DATA;
      end
      ST_DATA: state_nxt = ST_IDLE;
`ifdef AHP_SLAVE_ERROR_RESP_EN
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = HRESP_ERROR;
        state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
    // A new beat accepted in IDLE, DATA or ERR2 starts its own data phase.
    if (take) begin
`ifdef AHP_SLAVE_ERROR_RESP_EN
      if (addr_err) begin
        state_nxt = ST_ERR1;
      end else
`endif
      if (WAIT_STATES > 0) begin
        state_nxt = ST_WAIT;
        cnt_nxt   = WS;
      end else begin
        state_nxt = ST_DATA;
      end
    end
  end

  // State and wait counter; reset discards any pending transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the accepted address phase; errored writes never arm the RAM write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_idx   <= '0;
      ap_be    <= 4'b0000;
      ap_write <= 1'b0;
    end else if (take) begin
      ap_idx   <= addr_idx;
      ap_be    <= addr_be;
      ap_write <= HWRITE && !addr_err;
    end
  end

  // Read data register holds its value except on the single load edge of an OKAY read.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HRDATA <= '0;
    end else if (rd_load) begin
      HRDATA <= rd_merged;
    end
  end

endmodule
